instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/instr_mem.sv | 25 ++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the TPU instruction sequencer.
// Opcode map, opcode field position, word width and sequencer states.
package tpu_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   typedef enum logic [OPC_W-1:0] {
      OP_END         = 3'b000,
      OP_LOAD_ADDR   = 3'b001,
      OP_LOAD_WEIGHT = 3'b010,
      OP_LOAD_INPUT  = 3'b011,
      OP_COMPUTE     = 3'b100,
      OP_STORE       = 3'b101,
      OP_ILL6        = 3'b110,
      OP_ILL7        = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HOLD,
      S_DONE,
      S_ERROR
   } seq_state_e;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: program store for the sequencer.
// One synchronous write port, asynchronous read; contents survive reset.
module instr_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Program load write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches program words and issues them to the control unit.
// COMPUTE is held valid for COMPUTE_CYCLES; END stops, illegal ops and overrun fault.
module instr_sequencer #(
   parameter int IMEM_DEPTH     = 8,
   parameter int INSTR_W        = tpu_pkg::INSTR_W,
   parameter int COMPUTE_CYCLES = 6,
   localparam int AW            = $clog2(IMEM_DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               imem_wr_en,
   input  logic [AW-1:0]      imem_wr_addr,
   input  logic [INSTR_W-1:0] imem_wr_data,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [AW-1:0]      pc,
   output logic               busy,
   output logic               done,
   output logic               error
);

   import tpu_pkg::*;

   localparam int CW = $clog2(COMPUTE_CYCLES + 1);
   localparam logic [AW-1:0] PC_LAST  = AW'(IMEM_DEPTH - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(COMPUTE_CYCLES - 1);

   if (COMPUTE_CYCLES < 2) begin : g_bad_compute_cycles
      $fatal(1, "instr_sequencer: COMPUTE_CYCLES must be at least 2");
   end

   seq_state_e         state, state_nxt;
   logic [INSTR_W-1:0] ir, ir_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [AW-1:0]      pc_nxt;
   logic               done_nxt, error_nxt;
   logic               adv;
   logic [INSTR_W-1:0] rd_data;
   logic               mem_we;
   opcode_e            opc;
   logic               is_end, is_ill, is_comp;

   assign opc     = opcode_e'(ir[OPC_MSB:OPC_LSB]);
   assign is_end  = (opc == OP_END);
   assign is_ill  = (opc == OP_ILL6) || (opc == OP_ILL7);
   assign is_comp = (opc == OP_COMPUTE);
   assign mem_we  = imem_wr_en && !busy && !reset;

   instr_mem #(
      .DEPTH (IMEM_DEPTH),
      .W     (INSTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (imem_wr_addr),
      .wr_data (imem_wr_data),
      .rd_addr (pc),
      .rd_data (rd_data)
   );

   // State, pc, instruction register, hold counter and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
         error <= error_nxt;
      end
   end

   // Next-state decode and issue outputs
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir;
      cnt_nxt     = cnt;
      done_nxt    = done;
      error_nxt   = error;
      instruction = '0;
      instr_valid = 1'b0;
      busy        = 1'b0;
      adv         = 1'b0;
      unique case (state)
         S_FETCH: begin
            busy      = 1'b1;
            ir_nxt    = rd_data;
            state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            busy = 1'b1;
            unique case (1'b1)
               is_end: begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
               end
               is_ill: begin
                  state_nxt = S_ERROR;
                  error_nxt = 1'b1;
               end
               default: begin
                  instruction = ir;
                  instr_valid = 1'b1;
                  if (instr_ready) begin
                     if (is_comp) begin
                        cnt_nxt   = CW'(1);
                        state_nxt = S_HOLD;
                     end else begin
                        adv = 1'b1;
                     end
                  end
               end
            endcase
         end
         S_HOLD: begin
            busy        = 1'b1;
            instruction = ir;
            instr_valid = 1'b1;
            if (cnt == CNT_LAST) adv = 1'b1;
            else cnt_nxt = cnt + 1'b1;
         end
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = '0;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (adv) begin
         if (pc == PC_LAST) begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
         end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = S_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer.
// A program-walk model predicts the issued words; a negedge process checks every cycle.
module tb_instr_sequencer;

   localparam int DEPTH = 8;
   localparam int W     = 16;
   localparam int CC    = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          imem_wr_en = 1'b0;
   logic [2:0]    imem_wr_addr = '0;
   logic [W-1:0]  imem_wr_data = '0;
   logic          instr_ready = 1'b0;
   logic [W-1:0]  instruction;
   logic          instr_valid;
   logic [2:0]    pc;
   logic          busy, done, error;

   always #5 clk = ~clk;

   instr_sequencer #(
      .IMEM_DEPTH     (DEPTH),
      .INSTR_W        (W),
      .COMPUTE_CYCLES (CC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .imem_wr_en   (imem_wr_en),
      .imem_wr_addr (imem_wr_addr),
      .imem_wr_data (imem_wr_data),
      .instr_ready  (instr_ready),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   int nerr = 0;
   int nchk = 0;

   logic [W-1:0] prog [DEPTH];
   logic [W-1:0] exp_w [$];
   int           exp_pc [$];
   bit           sb_en = 1'b0;
   int           vcount = 0;
   int           comp_cnt = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Walk the program as the control unit would see it.
   function automatic void model(output bit e_done, output bit e_err,
                                 output int nominal);
      logic [W-1:0] w;
      exp_w.delete();
      exp_pc.delete();
      comp_cnt = 0;
      e_done   = 1'b0;
      e_err    = 1'b0;
      nominal  = 0;
      for (int a = 0; a < DEPTH; a++) begin
         w = prog[a];
         if (w[15:13] == 3'd0) begin
            e_done = 1'b1;
            return;
         end
         if (w[15:13] >= 3'd6) begin
            e_err = 1'b1;
            return;
         end
         exp_w.push_back(w);
         exp_pc.push_back(a);
         nominal += (w[15:13] == 3'd4) ? CC : 1;
      end
      e_err = 1'b1;
   endfunction

   // Per-cycle comparison against the expected issue queue
   always @(negedge clk) begin
      if (sb_en) begin
         if (instr_valid) begin
            vcount++;
            if (exp_w.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               chk("instruction", instruction, exp_w[0]);
               chk("pc", pc, exp_pc[0]);
               chk("busy_when_valid", busy, 1);
               if (exp_w[0][15:13] == 3'd4) begin
                  if (comp_cnt > 0 || instr_ready) comp_cnt++;
                  if (comp_cnt == CC) begin
                     void'(exp_w.pop_front());
                     void'(exp_pc.pop_front());
                     comp_cnt = 0;
                  end
               end else if (instr_ready) begin
                  void'(exp_w.pop_front());
                  void'(exp_pc.pop_front());
               end
            end
         end else begin
            chk("instr_zero_when_invalid", instruction, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog();
      for (int a = 0; a < DEPTH; a++) begin
         imem_wr_en   = 1'b1;
         imem_wr_addr = 3'(a);
         imem_wr_data = prog[a];
         tick();
      end
      imem_wr_en = 1'b0;
   endtask

   task automatic set_demo();
      prog = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
               16'h8000, 16'h2007, 16'hA000, 16'h0000};
   endtask

   // mode 0 random/full ready, 1 stall at pc 1, 2 start+write while busy,
   // 3 reset on third HOLD cycle, 4 write word 0 together with start
   task automatic run(input int pct, input int mode, output int vc);
      bit ed, ee;
      int nom, cyc, lat, stall, comp_seen;
      model(ed, ee, nom);
      vcount    = 0;
      sb_en     = 1'b1;
      lat       = -1;
      stall     = 3;
      comp_seen = 0;
      start     = 1'b1;
      if (mode == 4) begin
         imem_wr_en   = 1'b1;
         imem_wr_addr = '0;
         imem_wr_data = prog[0];
      end
      tick();
      start      = 1'b0;
      imem_wr_en = 1'b0;
      chk("fetch_busy", busy, 1);
      chk("fetch_pc", pc, 0);
      chk("fetch_valid", instr_valid, 0);
      cyc = 0;
      while (!(done || error) && cyc < 400) begin
         start      = 1'b0;
         imem_wr_en = 1'b0;
         if (instr_valid && lat < 0) lat = cyc;
         case (mode)
            1: begin
               if (instr_valid && pc == 3'd1 && stall > 0) begin
                  instr_ready = 1'b0;
                  stall--;
               end else begin
                  instr_ready = 1'b1;
               end
            end
            2: begin
               instr_ready = 1'b1;
               if (cyc == 5) begin
                  chk("busy_mid_run", busy, 1);
                  start        = 1'b1;
                  imem_wr_en   = 1'b1;
                  imem_wr_addr = '0;
                  imem_wr_data = 16'hE000;
               end
            end
            3: begin
               instr_ready = 1'b1;
               if (instr_valid && instruction[15:13] == 3'd4) comp_seen++;
               if (comp_seen == 4) begin
                  reset = 1'b1;
                  tick();
                  reset = 1'b0;
                  sb_en = 1'b0;
                  chk("abort_valid", instr_valid, 0);
                  chk("abort_pc", pc, 0);
                  chk("abort_busy", busy, 0);
                  chk("abort_instr", instruction, 0);
                  chk("abort_flags", {done, error}, 0);
                  tick();
                  chk("abort_stays_idle", {busy, instr_valid}, 0);
                  vc = vcount;
                  return;
               end
            end
            default: instr_ready = ($urandom_range(0, 99) < pct);
         endcase
         tick();
         cyc++;
      end
      sb_en       = 1'b0;
      instr_ready = 1'b0;
      if (cyc >= 400) chk("run_timeout", 32'd1, 32'd0);
      chk("first_valid_latency", lat, (nom > 0) ? 1 : -1);
      chk("done_flag", done, ed);
      chk("error_flag", error, ee);
      chk("end_busy", busy, 0);
      chk("end_valid", instr_valid, 0);
      chk("end_instr", instruction, 0);
      chk("queue_drained", exp_w.size(), 0);
      vc = vcount;
   endtask

   initial begin
      bit ed, ee;
      int nom, vc;
      // reset held with start and a write pending: both must lose
      reset        = 1'b1;
      start        = 1'b1;
      imem_wr_en   = 1'b1;
      imem_wr_data = 16'hE000;
      tick();
      tick();
      start      = 1'b0;
      imem_wr_en = 1'b0;
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      reset = 1'b0;
      tick();

      set_demo();
      load_prog();
      model(ed, ee, nom);
      chk("model_demo_nominal", nom, 12);
      chk("model_demo_issues", exp_w.size(), 7);
      chk("model_demo_done", ed, 1);
      run(100, 0, vc);
      chk("demo_valid_cycles", vc, 12);

      run(100, 1, vc);
      chk("stall_valid_cycles", vc, 15);

      run(100, 2, vc);
      chk("busy_start_write_cycles", vc, 12);
      run(100, 0, vc);
      chk("busy_write_ignored", vc, 12);

      reset        = 1'b1;
      start        = 1'b1;
      imem_wr_en   = 1'b1;
      imem_wr_addr = 3'd0;
      imem_wr_data = 16'hE000;
      tick();
      reset      = 1'b0;
      start      = 1'b0;
      imem_wr_en = 1'b0;
      chk("rst_beats_start", busy, 0);
      run(100, 0, vc);
      chk("rst_beats_write", vc, 12);

      run(100, 3, vc);
      chk("abort_valid_cycles", vc, 8);
      run(100, 0, vc);
      chk("rerun_after_abort", vc, 12);

      prog[2] = 16'hE000;
      load_prog();
      run(100, 0, vc);
      chk("illegal_valid_cycles", vc, 2);
      chk("illegal_error", error, 1);
      run(100, 0, vc);
      chk("restart_from_error", vc, 2);

      for (int a = 0; a < DEPTH; a++) prog[a] = 16'h4000;
      load_prog();
      model(ed, ee, nom);
      chk("model_overrun_err", ee, 1);
      run(100, 0, vc);
      chk("overrun_valid_cycles", vc, 8);
      chk("overrun_error", error, 1);
      chk("overrun_done", done, 0);

      set_demo();
      load_prog();
      prog[0] = 16'h0000;
      run(100, 4, vc);
      chk("write_with_start_cycles", vc, 0);
      chk("write_with_start_done", done, 1);

      for (int it = 0; it < 30; it++) begin
         int r;
         for (int a = 0; a < DEPTH; a++) begin
            r = $urandom_range(0, 19);
            prog[a] = 16'($urandom_range(0, 16'h1FFF));
            if (r == 0) prog[a][15:13] = 3'd0;
            else if (r == 1) prog[a][15:13] = 3'(6 + $urandom_range(0, 1));
            else prog[a][15:13] = 3'($urandom_range(1, 5));
         end
         load_prog();
         run($urandom_range(40, 100), 0, vc);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
